// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising checker for the 26-bit Fibonacci LFSR (taps 26,6,2,1)
// Define LFSR_CHK_RELOCK_EN to drop lock when a window collects ERR_THRESH mismatches.
module lfsr_checker #(
    parameter int ERR_THRESH = 8,
    parameter int WIN_LEN    = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:26]      hist
);

    if (ERR_THRESH < 1 || ERR_THRESH > WIN_LEN || WIN_LEN < 8 || WIN_LEN > 1024 ||
        (WIN_LEN & (WIN_LEN - 1)) != 0) begin : g_bad_cfg
        $error("lfsr_checker: illegal ERR_THRESH/WIN_LEN");
    end

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state_q;
    logic [1:26]      hist_q;
    logic [4:0]       fill_q;
    logic             locked_q;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic             pred;
    logic             mis;
    logic [1:26]      hunt_hist_d;
    logic [1:26]      fly_hist_d;
    logic [CNT_W-1:0] err_cnt_d;

    assign pred        = hist_q[1] ^ hist_q[2] ^ hist_q[6] ^ hist_q[26];
    assign mis         = din_valid && (state_q == LOCKED) && (din != pred);
    assign hunt_hist_d = {din, hist_q[1:25]};
    // Flywheel: the history advances on the prediction, so line errors never enter it.
    assign fly_hist_d  = {pred, hist_q[1:25]};

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr)
            err_cnt_d = '0;
        else if (mis && err_cnt_q != {CNT_W{1'b1}})
            err_cnt_d = err_cnt_q + CNT_W'(1);
    end

`ifdef LFSR_CHK_RELOCK_EN
    localparam int WIN_W = $clog2(WIN_LEN);
    localparam int THR_W = $clog2(ERR_THRESH + 1);

    logic [WIN_W-1:0] win_cnt_q;
    logic [THR_W-1:0] win_err_q;
    logic [THR_W-1:0] win_err_sum;
    logic             win_wrap;

    assign win_err_sum = win_err_q + THR_W'(mis);
    assign win_wrap    = (win_cnt_q == WIN_W'(WIN_LEN - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            hist_q    <= '0;
            fill_q    <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
`ifdef LFSR_CHK_RELOCK_EN
            win_cnt_q <= '0;
            win_err_q <= '0;
`endif
        end else begin
            err_q     <= mis;
            err_cnt_q <= err_cnt_d;
            if (din_valid) begin
                case (state_q)
                    HUNT: begin
                        hist_q <= hunt_hist_d;
                        if (fill_q == 5'd25) begin
                            // An all-zero history is the LFSR lock-up state; keep filling.
                            fill_q <= '0;
                            if (hunt_hist_d != '0) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            fill_q <= fill_q + 5'd1;
                        end
                    end
                    LOCKED: begin
                        hist_q <= fly_hist_d;
`ifdef LFSR_CHK_RELOCK_EN
                        win_cnt_q <= win_cnt_q + WIN_W'(1);
                        if (mis && win_err_sum == THR_W'(ERR_THRESH)) begin
                            state_q   <= HUNT;
                            locked_q  <= 1'b0;
                            fill_q    <= '0;
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                        end else if (win_wrap) begin
                            win_err_q <= THR_W'(mis);
                        end else begin
                            win_err_q <= win_err_sum;
                        end
`endif
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign hist    = hist_q;

endmodule
